cam_pixel_capture: RTL
======================

// Module: cam_pixel_capture
// PURPOSE
//  Camera-side capture stage that feeds the pixel writer.
//  - Samples the raw camera DVP bus (PCLK, VSYNC, HREF, D[7:0]) into the system clock domain.
//  - Emits each byte as a pixel_data/pixel_addr/pixel_WE write strobe, with the address incrementing per byte.
//  - Forwards a synchronised VSYNC.
//  - Flags frame end, address overflow and dropped bytes.
// PARAMETERS
//  ADDR_WIDTH    16  width of pixel_addr / byte counter
//  WE_CYCLES     2   clk cycles pixel_WE is held high per byte (1..7)
//  VSYNC_ACTIVE  0   cam_vsync level meaning "between frames"
//  HREF_ACTIVE   1   cam_href level meaning "byte valid on PCLK rise"
// PORTS
//  clk           in   1   system clock; must run >= 4x cam_pclk
//  reset         in   1   synchronous, active-high reset
//  capture_en    in   1   0 = hold block in idle (driven by writer's pixel_capture_reset)
//  cam_pclk      in   1   camera pixel clock, asynchronous
//  cam_vsync     in   1   camera frame sync, asynchronous
//  cam_href      in   1   camera line valid, asynchronous
//  cam_data      in   8   camera data byte, asynchronous
//  pixel_addr    out  ADDR_WIDTH  byte address of current write
//  pixel_data    out  8   byte being written
//  pixel_WE      out  1   write strobe, high WE_CYCLES clks per byte
//  pixel_vsync   out  1   cam_vsync after 2-flop synchroniser (same polarity)
//  frame_done    out  1   1-clk pulse when a captured frame ends
//  overflow      out  1   sticky: byte arrived with counter already at max
//  drop_err      out  1   sticky: PCLK edge arrived while pixel_WE still high
// BEHAVIOUR
//  Reset: pixel_addr=0, pixel_data=0, pixel_WE=0, frame_done=0, overflow=0, drop_err=0, state=IDLE.
//  - Synchroniser flops reset to the inactive levels (pclk 0, vsync=VSYNC_ACTIVE, href=!HREF_ACTIVE).
//  Sync: pclk/vsync/href/data each pass 2 flops; a 3rd pclk flop gives rise = s2 & ~s3.
//  - Data is taken from the same pipeline stage as the pclk edge, so it is aligned with it.
//  States:
//  - IDLE: wait for synced vsync == VSYNC_ACTIVE -> WAIT_FRAME.
//  - WAIT_FRAME: on vsync != VSYNC_ACTIVE -> CAPTURE; clear byte counter to 0.
//  - CAPTURE: on rise with href == HREF_ACTIVE, launch a write.
//    - On vsync == VSYNC_ACTIVE -> WAIT_FRAME and pulse frame_done for 1 clk.
//    - An in-flight write completes first, and frame_done fires in the cycle pixel_WE falls.
//  Write timing:
//  - Edge detected in cycle N -> in N+1, pixel_data = byte, pixel_addr = counter, and pixel_WE = 1.
//  - pixel_WE is held through N+WE_CYCLES and is 0 in N+WE_CYCLES+1.
//  - The counter increments in the cycle pixel_WE falls.
//  - pixel_addr and pixel_data stay stable until the next write launches.
//  Boundaries:
//  - Rise while pixel_WE high: the byte is dropped, drop_err set, and the current write is unaffected.
//  - Rise with counter = 2^ADDR_WIDTH-1 already written: no write, overflow set, no wrap.
//    - Overflow and drop_err stay set until reset or the next WAIT_FRAME->CAPTURE transition.
//  - Rise with href inactive: ignored.
//  - capture_en=0 (sampled each clk): state -> IDLE, pixel_WE -> 0 next clk, counter -> 0, flags cleared.
//    - pixel_vsync keeps tracking.
//  - reset or capture_en deasserted mid-frame: no partial-frame capture.
//    - The block must see vsync active, then inactive, before writing again.
//  - Simultaneous vsync-active and rise in CAPTURE: vsync wins and the byte is discarded.
//  pixel_vsync is always live and is not gated by state.
// TESTING
//  1 Reset, capture_en=1, vsync active 20 clk then inactive; 4 PCLK rises (period 8 clk), href=1, data A0,A1,A2,A3.
//    -> 4 pixel_WE pulses, 2 clk wide; addr 0,1,2,3; data A0..A3.
//  2 Frame of 6 bytes, then vsync goes active -> frame_done 1 pulse; next frame restarts at addr 0.
//  3 href=0 on 2 of 5 rises -> 3 writes only, at addr 0,1,2.
//  4 ADDR_WIDTH=4, 17 bytes -> writes addr 0..15, 17th byte produces no WE, overflow=1.
//  5 WE_CYCLES=7, PCLK period 5 clk -> drop_err=1, and no write overlaps another.
//  6 reset pulsed mid-frame with vsync still inactive -> no writes until a full vsync active->inactive cycle.
//    capture_en=0 mid-write -> pixel_WE=0 next clk.

Source files
------------

// File: rtl/cam_pixel_capture.sv
// DVP camera capture: synchronises PCLK/VSYNC/HREF/D into clk and turns each
// valid byte into an addressed write strobe held for WE_CYCLES clocks.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | disabled or just reset; waiting to see vsync active
// WAIT_FRAME | between frames; waiting for vsync to go inactive
// CAPTURE    | inside a frame; each valid PCLK rise launches a byte write
module cam_pixel_capture #(
   parameter int ADDR_WIDTH   = 16,
   parameter int WE_CYCLES    = 2,
   parameter bit VSYNC_ACTIVE = 1'b0,
   parameter bit HREF_ACTIVE  = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  capture_en,
   input  logic                  cam_pclk,
   input  logic                  cam_vsync,
   input  logic                  cam_href,
   input  logic [7:0]            cam_data,
   output logic [ADDR_WIDTH-1:0] pixel_addr,
   output logic [7:0]            pixel_data,
   output logic                  pixel_WE,
   output logic                  pixel_vsync,
   output logic                  frame_done,
   output logic                  overflow,
   output logic                  drop_err
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FRAME = 2'd1,
      CAPTURE    = 2'd2
   } state_t;

   localparam logic [2:0]            WE_LOAD  = 3'(WE_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

   state_t                state;
   logic                  pclk_s1, pclk_s2, pclk_s3;
   logic                  vsync_s1, vsync_s2;
   logic                  href_s1, href_s2;
   logic [7:0]            data_s1, data_s2;
   logic [2:0]            we_cnt;
   logic [1:0]            prime_cnt;
   logic [ADDR_WIDTH-1:0] byte_cnt;
   logic                  cnt_full;

   logic pclk_rise;
   logic vsync_act;
   logic href_act;
   logic we_last;

   always_ff @(posedge clk) begin
      if (reset) begin
         pclk_s1  <= 1'b0;
         pclk_s2  <= 1'b0;
         pclk_s3  <= 1'b0;
         vsync_s1 <= VSYNC_ACTIVE;
         vsync_s2 <= VSYNC_ACTIVE;
         href_s1  <= ~HREF_ACTIVE;
         href_s2  <= ~HREF_ACTIVE;
         data_s1  <= 8'h00;
         data_s2  <= 8'h00;
      end else begin
         pclk_s1  <= cam_pclk;
         pclk_s2  <= pclk_s1;
         pclk_s3  <= pclk_s2;
         vsync_s1 <= cam_vsync;
         vsync_s2 <= vsync_s1;
         href_s1  <= cam_href;
         href_s2  <= href_s1;
         data_s1  <= cam_data;
         data_s2  <= data_s1;
      end
   end

   assign pclk_rise   = pclk_s2 & ~pclk_s3;
   assign vsync_act   = (vsync_s2 == VSYNC_ACTIVE);
   assign href_act    = (href_s2 == HREF_ACTIVE);
   assign we_last     = pixel_WE && (we_cnt == 3'd0);
   assign pixel_vsync = vsync_s2;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         pixel_addr <= '0;
         pixel_data <= 8'h00;
         pixel_WE   <= 1'b0;
         we_cnt     <= 3'd0;
         prime_cnt  <= 2'd2;
         byte_cnt   <= '0;
         cnt_full   <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
         drop_err   <= 1'b0;
      end else begin
         // vsync_s2 still holds its reset value for two clocks after reset;
         // ignore it until real samples have propagated so a mid-frame reset
         // cannot fake a vsync-active observation.
         if (prime_cnt != 2'd0)
            prime_cnt <= prime_cnt - 2'd1;

         if (!capture_en) begin
            state      <= IDLE;
            pixel_WE   <= 1'b0;
            we_cnt     <= 3'd0;
            byte_cnt   <= '0;
            cnt_full   <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            drop_err   <= 1'b0;
         end else begin
            frame_done <= 1'b0;

            if (pixel_WE) begin
               if (we_cnt == 3'd0) begin
                  pixel_WE <= 1'b0;
                  if (byte_cnt == ADDR_MAX)
                     cnt_full <= 1'b1;
                  else
                     byte_cnt <= byte_cnt + 1'b1;
               end else begin
                  we_cnt <= we_cnt - 3'd1;
               end
            end

            case (state)
               IDLE: begin
                  if (prime_cnt == 2'd0 && vsync_act)
                     state <= WAIT_FRAME;
               end
               WAIT_FRAME: begin
                  if (!vsync_act) begin
                     state    <= CAPTURE;
                     byte_cnt <= '0;
                     cnt_full <= 1'b0;
                     overflow <= 1'b0;
                     drop_err <= 1'b0;
                  end
               end
               CAPTURE: begin
                  // Frame end waits for an in-flight write; new bytes are discarded meanwhile.
                  if (vsync_act) begin
                     if (!pixel_WE || we_last) begin
                        frame_done <= 1'b1;
                        state      <= WAIT_FRAME;
                     end
                  end else if (pclk_rise && href_act) begin
                     if (pixel_WE) begin
                        drop_err <= 1'b1;
                     end else if (cnt_full) begin
                        overflow <= 1'b1;
                     end else begin
                        pixel_WE   <= 1'b1;
                        we_cnt     <= WE_LOAD;
                        pixel_addr <= byte_cnt;
                        pixel_data <= data_s2;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
